// File: rtl/ex_div.sv
// ex_div: multi-cycle 32-bit integer divider for the EX stage.
// Uses radix-2 restoring division, one quotient bit per cycle. A divide takes
// 34 clock edges (1 load + 32 iterate + 1 sign fix-up). Divide by zero takes
// 2 edges and returns 64'h0.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   signed_div_i  1 = DIV (signed), 0 = DIVU
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       divide request, held high until ready_o is seen
//   annul_i       cancels the in-flight divide (flush/exception)
//   result_o      {remainder, quotient}, registered
//   ready_o       result valid, registered
//   stallreq_o    start_i & ~ready_o, freezes the earlier pipeline stages
module ex_div #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stallreq_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_e;

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [2*DATA_W:0]      work_q;
    logic [DATA_W-1:0]      divisor_q;
    logic                   signed_q;
    logic                   op1_neg_q;
    logic                   op2_neg_q;
    logic [2*DATA_W-1:0]    result_q;
    logic                   ready_q;

    logic [DATA_W-1:0]      op1_abs_d;
    logic [DATA_W-1:0]      op2_abs_d;
    logic [DATA_W:0]        diff_d;
    logic [2*DATA_W:0]      work_d;
    logic [DATA_W-1:0]      quot_d;
    logic [DATA_W-1:0]      rem_d;

    // Two's complement negation mod 2^DATA_W when en is set.
    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                   input logic              en);
        logic [DATA_W-1:0] r;
        if (en) begin
            r = (~v) + {{(DATA_W-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Operand magnitudes, one restoring step and the final sign fix-up.
    always_comb begin
        op1_abs_d = cond_neg(opdata1_i, signed_div_i & opdata1_i[DATA_W-1]);
        op2_abs_d = cond_neg(opdata2_i, signed_div_i & opdata2_i[DATA_W-1]);
        // Partial remainder (with next dividend bit) minus divisor; bit DATA_W
        // is the borrow, i.e. the partial remainder was smaller.
        diff_d    = {1'b0, work_q[2*DATA_W-1:DATA_W]} - {1'b0, divisor_q};
        if (diff_d[DATA_W]) begin
            work_d = {work_q[2*DATA_W-1:0], 1'b0};
        end else begin
            work_d = {diff_d[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};
        end
        quot_d = cond_neg(work_q[DATA_W-1:0], signed_q & (op1_neg_q ^ op2_neg_q));
        rem_d  = cond_neg(work_q[2*DATA_W:DATA_W+1], signed_q & op1_neg_q);
    end

    // Divider FSM with registered result and ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            work_q    <= {(2*DATA_W+1){1'b0}};
            divisor_q <= {DATA_W{1'b0}};
            signed_q  <= 1'b0;
            op1_neg_q <= 1'b0;
            op2_neg_q <= 1'b0;
            result_q  <= {(2*DATA_W){1'b0}};
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q  <= 1'b0;
                    result_q <= {(2*DATA_W){1'b0}};
                    if (start_i && !annul_i) begin
                        signed_q  <= signed_div_i;
                        op1_neg_q <= opdata1_i[DATA_W-1];
                        op2_neg_q <= opdata2_i[DATA_W-1];
                        if (opdata2_i == {DATA_W{1'b0}}) begin
                            state_q <= S_BYZERO;
                        end else begin
                            state_q   <= S_ON;
                            cnt_q     <= {CNT_W{1'b0}};
                            divisor_q <= op2_abs_d;
                            work_q    <= {{DATA_W{1'b0}}, op1_abs_d, 1'b0};
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_BYZERO: begin
                    work_q   <= {(2*DATA_W+1){1'b0}};
                    result_q <= {(2*DATA_W){1'b0}};
                    if (annul_i) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b0;
                    end else begin
                        state_q <= S_END;
                        ready_q <= 1'b1;
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        state_q  <= S_IDLE;
                        ready_q  <= 1'b0;
                        result_q <= {(2*DATA_W){1'b0}};
                    end else if (cnt_q != CNT_W'(DATA_W)) begin
                        work_q <= work_d;
                        cnt_q  <= cnt_q + CNT_W'(1);
                    end else begin
                        result_q <= {rem_d, quot_d};
                        ready_q  <= 1'b1;
                        state_q  <= S_END;
                    end
                end
                S_END: begin
                    // Only a dropped start (or a flush) releases the result;
                    // a still-high start never restarts the divider.
                    if (!start_i || annul_i) begin
                        state_q  <= S_IDLE;
                        ready_q  <= 1'b0;
                        result_q <= {(2*DATA_W){1'b0}};
                    end else begin
                        state_q <= S_END;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    ready_q  <= 1'b0;
                    result_q <= {(2*DATA_W){1'b0}};
                end
            endcase
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = start_i & ~ready_q;

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: self-checking bench for ex_div. A plain-arithmetic reference
// (magnitude divide, then sign fix) produces every expected result.
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_div #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    // Reference: {remainder, quotient} following truncating division.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] ua, ub, q, r;
        logic        na, nb;
        if (b == 32'd0) return 64'd0;
        na = s && a[31];
        nb = s && b[31];
        ua = na ? (32'd0 - a) : a;
        ub = nb ? (32'd0 - b) : b;
        q  = ua / ub;
        r  = ua % ub;
        if (na ^ nb) q = 32'd0 - q;
        if (na)      r = 32'd0 - r;
        return {r, q};
    endfunction

    // Starts a divide from IDLE, scrambles the operands after the load edge,
    // and checks latency, stall behaviour and the result. Leaves start_i high.
    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] res);
        int          edges;
        int          stall_cnt;
        int          exp_lat;
        logic [63:0] exp_res;
        exp_lat = (b == 32'd0) ? 2 : 34;
        exp_res = ref_div(s, a, b);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        edges        = 0;
        stall_cnt    = 0;
        res          = 64'd0;
        #1;
        checks++;
        if (stallreq_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_at_start: got %b expected 1", stallreq_o);
        end
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~s;
            end
            if (ready_o === 1'b1) begin
                edges = n;
                res   = result_o;
                break;
            end
            if (stallreq_o === 1'b1) stall_cnt++;
        end
        checks++;
        if (edges != exp_lat) begin
            errors++;
            $display("FAIL latency: got %0d edges expected %0d (s=%b a=%h b=%h)",
                     edges, exp_lat, s, a, b);
        end
        checks++;
        if (stall_cnt != exp_lat - 1) begin
            errors++;
            $display("FAIL stall_count: got %0d expected %0d", stall_cnt, exp_lat - 1);
        end
        checks++;
        if (res !== exp_res) begin
            errors++;
            $display("FAIL result: got %h expected %h (s=%b a=%h b=%h)",
                     res, exp_res, s, a, b);
        end
        checks++;
        if (stallreq_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_at_ready: got %b expected 0", stallreq_o);
        end
    endtask

    // Drops start_i and checks the block returns to IDLE with cleared outputs.
    task automatic finish_div();
        start_i = 1'b0;
        #1;
        checks++;
        if (stallreq_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_after_drop: got %b expected 0", stallreq_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++;
            $display("FAIL release: got ready=%b result=%h expected 0/0", ready_o, result_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = 32'd0; opdata2_i = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0 || stallreq_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b result=%h stall=%b expected 0/0/0",
                     ready_o, result_o, stallreq_o);
        end
        // Reset dominates a pending start.
        start_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0 || stallreq_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_wins: got ready=%b stall=%b expected 0/1", ready_o, stallreq_o);
        end
        start_i = 1'b0;
        rst     = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic        s_t [9]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] a_t [9]   = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFFF,
                                   32'd123, 32'd5, 32'd77, 32'h80000000};
        logic [31:0] b_t [9]   = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1,
                                   32'd0, 32'd9, 32'd0, 32'd3};
        logic [63:0] e_t [9]   = '{64'h00000002_0000000E, 64'hFFFFFFFF_FFFFFFFD,
                                   64'h00000001_FFFFFFFD, 64'h00000000_80000000,
                                   64'h00000000_FFFFFFFF, 64'h0, 64'h00000005_00000000,
                                   64'h0, 64'hFFFFFFFE_D5555556};
        logic [63:0] res;
        for (int i = 0; i < 9; i++) begin
            do_div(s_t[i], a_t[i], b_t[i], res);
            checks++;
            if (res !== e_t[i]) begin
                errors++;
                $display("FAIL directed_%0d: got %h expected %h", i, res, e_t[i]);
            end
            finish_div();
        end
    endtask

    task automatic test_random();
        logic [63:0] res;
        logic [31:0] a, b;
        logic        s;
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(1, 0));
            a = $urandom;
            case ($urandom_range(4, 0))
                0:       b = 32'($urandom_range(15, 1));
                1:       b = 32'hFFFFFFFF - 32'($urandom_range(3, 0));
                2:       b = 32'd0;
                3:       b = 32'h80000000;
                default: b = $urandom;
            endcase
            if (i % 6 == 5) a = 32'h80000000;
            do_div(s, a, b, res);
            finish_div();
        end
    endtask

    task automatic test_annul();
        logic [63:0] res;
        int          seen;
        signed_div_i = 1'b0; opdata1_i = 32'd12345; opdata2_i = 32'd7;
        annul_i = 1'b0; start_i = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++;
            $display("FAIL annul_on: got ready=%b result=%h expected 0/0", ready_o, result_o);
        end
        // A start accompanied by annul must not launch a divide.
        repeat (2) @(posedge clk);
        #1;
        annul_i = 1'b0; start_i = 1'b0;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (ready_o !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL annul_no_ready: got %0d ready cycles expected 0", seen);
        end
        do_div(1'b0, 32'd12345, 32'd7, res);
        finish_div();
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        int          seen;
        signed_div_i = 1'b0; opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'd3;
        annul_i = 1'b0; start_i = 1'b1;
        repeat (22) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid: got ready=%b result=%h expected 0/0", ready_o, result_o);
        end
        rst = 1'b0; start_i = 1'b0;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (ready_o !== 1'b0 || stallreq_o !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_idle: got %0d active cycles expected 0", seen);
        end
        do_div(1'b1, 32'hFFFFFF00, 32'd16, res);
        finish_div();
    endtask

    task automatic test_back_to_back();
        logic [63:0] res;
        logic [63:0] held;
        do_div(1'b0, 32'd100, 32'd7, held);
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1;
            checks++;
            if (ready_o !== 1'b1 || result_o !== 64'h00000002_0000000E) begin
                errors++;
                $display("FAIL hold_%0d: got ready=%b result=%h expected 1/%h",
                         n, ready_o, result_o, 64'h00000002_0000000E);
            end
        end
        start_i = 1'b0;
        @(posedge clk);
        #1;
        do_div(1'b0, 32'd1000, 32'd10, res);
        checks++;
        if (res !== 64'h00000000_00000064) begin
            errors++;
            $display("FAIL back_to_back: got %h expected %h", res, 64'h00000000_00000064);
        end
        finish_div();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_annul();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
